// File: rtl/polar_sc_pkg.sv
// Shared definitions for the polar successive-cancellation datapath:
// partial-sum FSM state encoding and code-length helper.
package polar_sc_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } ps_state_e;

  localparam int unsigned DefaultLogN = 3;

  // Code length N = 2**n for a given n.
  function automatic int unsigned code_len(input int unsigned log_n);
    return 32'd1 << log_n;
  endfunction

  localparam int unsigned DefaultN = code_len(DefaultLogN);

endpackage

// File: rtl/polar_generator_row.sv
// Combinational generator of one row of F^(kron n), F = [[1,0],[1,1]]:
// row[j] is set exactly when the bits of j are a subset of the bits of index.
module polar_generator_row
  import polar_sc_pkg::*;
#(
  parameter int unsigned n = 3
) (
  input  logic [n-1:0]      index,
  output logic [2**n-1:0]   row
);

  localparam int N = int'(code_len(n));

  always_comb begin
    row = '0;
    for (int j = 0; j < N; j++) begin
      row[j] = ((index & n'(j)) == n'(j));
    end
  end

endmodule

// File: rtl/partial_sums_update_unit.sv
// Accumulates the partial-sum vector x = u * G_N as decided bits arrive,
// one bit per transfer, and signals frame completion.
module partial_sums_update_unit
  import polar_sc_pkg::*;
#(
  parameter int unsigned n = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              u_valid,
  input  logic              u_bit,
  output logic              u_ready,
  output logic [2**n-1:0]   S,
  output logic [n-1:0]      bit_index,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned N = code_len(n);
  localparam logic [n-1:0] LastIdx = n'(N - 1);

  ps_state_e       state_q, state_d;
  logic [N-1:0]    s_q, s_d;
  logic [n-1:0]    idx_q, idx_d;
  logic [N-1:0]    row;

  polar_generator_row #(
    .n(n)
  ) u_row (
    .index(idx_q),
    .row  (row)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          s_d     = '0;
          idx_d   = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        // An abort takes priority; a coincident transfer is dropped.
        if (frame_start) begin
          s_d   = '0;
          idx_d = '0;
        end else if (u_valid) begin
          if (u_bit) begin
            s_d = s_q ^ row;
          end
          idx_d = idx_q + n'(1);
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (frame_start) begin
          s_d     = '0;
          idx_d   = '0;
          state_d = StAccum;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      s_q     <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
    end
  end

  assign S          = s_q;
  assign bit_index  = idx_q;
  assign u_ready    = (state_q == StAccum);
  assign busy       = (state_q == StAccum);
  assign frame_done = (state_q == StDone);

endmodule

// File: tb/tb_partial_sums_update_unit.sv
// Bench for partial_sums_update_unit (n = 3): directed cases plus random traffic
// checked against a reference model; completed frames verified via a scoreboard.
module tb_partial_sums_update_unit;

  localparam int unsigned LogN = 3;
  localparam int unsigned N    = 8;

  logic           clk = 1'b0;
  logic           rst, frame_start, u_valid, u_bit;
  logic           u_ready, busy, frame_done;
  logic [N-1:0]   s;
  logic [LogN-1:0] bit_index;

  partial_sums_update_unit #(
    .n(LogN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .u_valid    (u_valid),
    .u_bit      (u_bit),
    .u_ready    (u_ready),
    .S          (s),
    .bit_index  (bit_index),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] exp_q[$];

  // Reference model: accepted decided bits, next index, phase (0 idle, 1 accum, 2 done).
  bit m_u[N];
  int m_idx;
  int m_st;

  // x[j] = XOR of u_i over every i whose bits contain those of j.
  function automatic logic [N-1:0] encode();
    logic [N-1:0] x;
    x = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (m_u[i] && ((i & j) == j)) x[j] = ~x[j];
      end
    end
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < N; i++) m_u[i] = 1'b0;
    m_idx = 0;
  endtask

  task automatic step(input bit r, input bit fs, input bit v, input bit b);
    @(negedge clk);
    rst = r; frame_start = fs; u_valid = v; u_bit = b;
    @(posedge clk);
    if (r) begin
      m_clear();
      m_st = 0;
    end else begin
      case (m_st)
        0: if (fs) begin m_clear(); m_st = 1; end
        1: begin
          if (fs) m_clear();
          else if (v) begin
            m_u[m_idx] = b;
            if (m_idx == N - 1) begin
              m_idx = 0;
              m_st  = 2;
              exp_q.push_back(encode());
            end else begin
              m_idx++;
            end
          end
        end
        default: begin
          if (fs) begin m_clear(); m_st = 1; end
          else m_st = 0;
        end
      endcase
    end
    #1;
    chk("S", int'(s), int'(encode()));
    chk("bit_index", int'(bit_index), m_idx);
    chk("u_ready", int'(u_ready), int'(m_st == 1));
    chk("busy", int'(busy), int'(m_st == 1));
    chk("frame_done", int'(frame_done), int'(m_st == 2));
  endtask

  task automatic run_frame(input logic [N-1:0] u, input bit gaps);
    step(0, 1, 0, 0);
    for (int i = 0; i < N; i++) begin
      step(0, 0, 1, u[i]);
      if (gaps) begin
        step(0, 0, 0, 0);
        step(0, 0, 1'b0, 1'b1);
      end
    end
  endtask

  // Scoreboard monitor: a completed frame presents frame_done with the final S.
  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("frame_unexpected", 1, 0);
      end else begin
        logic [N-1:0] e;
        e = exp_q.pop_front();
        chk("frame_S", int'(s), int'(e));
      end
    end
  end

  initial begin
    rst = 1'b1; frame_start = 1'b0; u_valid = 1'b0; u_bit = 1'b0;
    m_clear();
    m_st = 0;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset_S", int'(s), 0);
    chk("reset_ready", int'(u_ready), 0);

    // u_valid while idle is ignored
    step(0, 0, 1, 1);

    run_frame(8'h01, 1'b0);
    chk("frame_u0", int'(s), 8'h01);
    step(0, 0, 0, 0);
    chk("hold_after_done", int'(s), 8'h01);

    run_frame(8'h08, 1'b0);
    chk("frame_u3", int'(s), 8'h0F);
    run_frame(8'h80, 1'b0);
    chk("frame_u7", int'(s), 8'hFF);
    step(0, 0, 0, 0);
    run_frame(8'hFF, 1'b1);
    chk("frame_all_gaps", int'(s), 8'h80);

    // Abort after 4 transfers with a coincident transfer
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1'($urandom_range(0, 1)));
    step(0, 1, 1, 1);
    chk("abort_S", int'(s), 0);
    chk("abort_idx", int'(bit_index), 0);
    chk("abort_ready", int'(u_ready), 1);

    // Reset mid-frame at bit_index 5
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
    chk("pre_rst_idx", int'(bit_index), 5);
    step(1, 0, 1, 1);
    chk("rst_mid_S", int'(s), 0);
    chk("rst_mid_ready", int'(u_ready), 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    chk("ignored_idx", int'(bit_index), 0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
